instr_fetch_unit: RTL

- Instruction-fetch stage directly downstream of the program counter in the multi-cycle RV32 core.
- On a fetch command from the control unit, takes the PC's byte address and issues a single-word read to instruction memory over a req/ready handshake.
- Captures the returned word into the instruction register for the decoder and flags alignment, range, timeout and non-32-bit-encoding errors.

---
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: issues one-word reads to instruction memory over a
// req/ready handshake and captures the result into the instruction register.
module instr_fetch_unit #(
  parameter logic [31:0] IMEM_BASE = 32'h0100_0000,
  parameter logic [31:0] IMEM_LAST = 32'h0100_0FFC,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fetch_start,
  input  logic [31:0] instr_addr,
  input  logic        halt,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        fetch_done,
  output logic        instr_illegal,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FAULT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [7:0] cnt;
  logic       accept, misaligned, out_of_range, timed_out, got_data;

  always_comb begin
    misaligned   = (instr_addr[1:0] != 2'b00);
    out_of_range = (instr_addr < IMEM_BASE) || (instr_addr > IMEM_LAST);
    accept       = (state == S_IDLE) && fetch_start && !halt;
    got_data     = (state == S_WAIT) && mem_ready;
    // ready on the final counted edge wins over the timeout
    timed_out    = (state == S_WAIT) && !mem_ready && (cnt == CNT_LAST);
    state_nx     = state;
    case (state)
      S_IDLE:  if (accept) state_nx = (misaligned || out_of_range) ? S_FAULT : S_WAIT;
      S_WAIT:  if (got_data) state_nx = S_IDLE;
               else if (timed_out) state_nx = S_FAULT;
      S_FAULT: state_nx = S_FAULT;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      instr         <= NOP_INSTR;
      instr_pc      <= '0;
      instr_valid   <= 1'b0;
      fetch_done    <= 1'b0;
      instr_illegal <= 1'b0;
      fault         <= 1'b0;
      fault_code    <= 2'b00;
      cnt           <= '0;
    end else begin
      fetch_done <= 1'b0;
      if (accept) begin
        if (misaligned) begin
          fault      <= 1'b1;
          fault_code <= 2'b01;
        end else if (out_of_range) begin
          fault      <= 1'b1;
          fault_code <= 2'b10;
        end else begin
          mem_addr    <= instr_addr;
          mem_req     <= 1'b1;
          instr_valid <= 1'b0;
          cnt         <= '0;
        end
      end else if (got_data) begin
        instr         <= mem_rdata;
        instr_pc      <= mem_addr;
        instr_valid   <= 1'b1;
        instr_illegal <= (mem_rdata[1:0] != 2'b11);
        fetch_done    <= 1'b1;
        mem_req       <= 1'b0;
      end else if (timed_out) begin
        mem_req    <= 1'b0;
        fault      <= 1'b1;
        fault_code <= 2'b11;
      end else if (state == S_WAIT) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule
